// File: rtl/per_bus_hub_if.sv
// Core-side request/response channel plus shared peripheral bus of the hub.
// The slave modport is the hub's view; master is the core and peripheral side.
`timescale 1ns/1ps
interface per_bus_hub_if #(
  parameter int NUM_PER = 4,
  parameter int SEL_W   = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16
);
  logic                      mValid;
  logic                      mReady;
  logic                      mWrite;
  logic [SEL_W-1:0]          mSel;
  logic [ADDR_W-1:0]         mAddr;
  logic [DATA_W-1:0]         mWdata;
  logic                      mRvalid;
  logic                      mRready;
  logic [DATA_W-1:0]         mRdata;
  logic                      mErr;
  logic [NUM_PER-1:0]        pValid;
  logic                      pWrite;
  logic [ADDR_W-1:0]         pAddr;
  logic [DATA_W-1:0]         pWdata;
  logic [NUM_PER-1:0]        pAck;
  logic [NUM_PER*DATA_W-1:0] pRdata;

  modport slave (
    input  mValid, mWrite, mSel, mAddr, mWdata, mRready, pAck, pRdata,
    output mReady, mRvalid, mRdata, mErr, pValid, pWrite, pAddr, pWdata
  );

  modport master (
    output mValid, mWrite, mSel, mAddr, mWdata, mRready, pAck, pRdata,
    input  mReady, mRvalid, mRdata, mErr, pValid, pWrite, pAddr, pWdata
  );
endinterface

// File: rtl/per_bus_hub.sv
// Peripheral-bus hub: one master fans out to NUM_PER peripherals by select field,
// one transaction in flight, with bus timeout and held error/data response.
`timescale 1ns/1ps
module per_bus_hub #(
  parameter int NUM_PER = 4,
  parameter int SEL_W   = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic           fastClk,
  input logic           rstN,
  per_bus_hub_if.slave  bus
);
   localparam int                CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [SEL_W:0]    NUM_PER_L = (SEL_W + 1)'(NUM_PER);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

   state_t              r_state, w_next;
   logic                r_ready;
   logic [NUM_PER-1:0]  r_pvalid;
   logic                r_pwrite;
   logic [ADDR_W-1:0]   r_paddr;
   logic [DATA_W-1:0]   r_pwdata;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_rvalid;
   logic                r_err;
   logic [DATA_W-1:0]   r_rdata;

   logic                w_accept, w_sel_ok, w_ack, w_timeout;
   logic [NUM_PER-1:0]  w_onehot;
   logic [DATA_W-1:0]   w_sel_rdata;

   // NOTE: combinational logic assigns every output a default first, so no latch is inferred.
   always_comb begin
      w_accept    = (r_state == S_IDLE) && r_ready && bus.mValid;
      w_sel_ok    = {1'b0, bus.mSel} < NUM_PER_L;
      w_onehot    = NUM_PER'(1) << bus.mSel;
      w_ack       = |(bus.pAck & r_pvalid);
      w_timeout   = (TIMEOUT > 0) && (r_cnt == CNT_LAST);
      w_sel_rdata = '0;
      for (int i = 0; i < NUM_PER; i++) begin
         if (r_pvalid[i]) w_sel_rdata = bus.pRdata[i*DATA_W +: DATA_W];
      end
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = w_sel_ok ? S_REQ : S_RESP;
         S_REQ:   if (w_ack || w_timeout) w_next = S_RESP;
         S_RESP:  if (bus.mRready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge fastClk) begin
      if (!rstN) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge fastClk) begin
      if (!rstN) begin
         r_ready  <= 1'b0;
         r_pvalid <= '0;
         r_pwrite <= 1'b0;
         r_paddr  <= '0;
         r_pwdata <= '0;
         r_cnt    <= '0;
         r_rvalid <= 1'b0;
         r_err    <= 1'b0;
         r_rdata  <= '0;
      end else begin
         r_ready <= (w_next == S_IDLE);
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (w_sel_ok) begin
                     r_pvalid <= w_onehot;
                     r_pwrite <= bus.mWrite;
                     r_paddr  <= bus.mAddr;
                     r_pwdata <= bus.mWdata;
                     r_cnt    <= '0;
                  end else begin
                     r_rvalid <= 1'b1;
                     r_err    <= 1'b1;
                     r_rdata  <= '0;
                  end
               end
            end
            S_REQ: begin
               // Saturate rather than wrap so a disabled timeout never retriggers.
               if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
               if (w_ack || w_timeout) begin
                  r_pvalid <= '0;
                  r_pwrite <= 1'b0;
                  r_paddr  <= '0;
                  r_pwdata <= '0;
                  r_rvalid <= 1'b1;
                  r_err    <= !w_ack;
                  r_rdata  <= (w_ack && !r_pwrite) ? w_sel_rdata : '0;
               end
            end
            S_RESP: begin
               if (bus.mRready) begin
                  r_rvalid <= 1'b0;
                  r_err    <= 1'b0;
                  r_rdata  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.mReady  = r_ready;
   assign bus.mRvalid = r_rvalid;
   assign bus.mRdata  = r_rdata;
   assign bus.mErr    = r_err;
   assign bus.pValid  = r_pvalid;
   assign bus.pWrite  = r_pwrite;
   assign bus.pAddr   = r_paddr;
   assign bus.pWdata  = r_pwdata;
endmodule
